// File: rtl/ysyx_23060124_idu_pkg.sv
// Shared constants and types for the ysyx_23060124 decode stage.
// Opcode map, ALU operation codes, immediate formats and the handshake state.
package ysyx_23060124_idu_pkg;

  localparam int          ISA_WIDTH = 32;
  localparam logic [31:0] RESET_PC  = 32'h8000_0000;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_INS    = 32'h0000_0013;
  localparam logic [31:0] ECALL_INS  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_INS = 32'h0010_0073;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  // IMM_Z marks instructions without an immediate; the bundle then carries 0.
  typedef enum logic [2:0] {
    IMM_Z = 3'd0,
    IMM_I = 3'd1,
    IMM_S = 3'd2,
    IMM_B = 3'd3,
    IMM_U = 3'd4,
    IMM_J = 3'd5
  } imm_fmt_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } idu_state_e;

  // alt selects SUB for funct3=0 and SRA for funct3=5.
  function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ysyx_23060124_imm_gen.sv
// Immediate extraction and sign extension for the RV32I instruction formats.
// Bits [6:0] are never part of an immediate, so only [31:7] come in.
module ysyx_23060124_imm_gen #(
  parameter int ISA_WIDTH = 32
) (
  input  logic [ISA_WIDTH-1:7]             i_ins,
  input  ysyx_23060124_idu_pkg::imm_fmt_e i_fmt,
  output logic [ISA_WIDTH-1:0]             o_imm
);
  import ysyx_23060124_idu_pkg::*;

  always_comb begin
    o_imm = '0;
    case (i_fmt)
      IMM_I:   o_imm = {{20{i_ins[31]}}, i_ins[31:20]};
      IMM_S:   o_imm = {{20{i_ins[31]}}, i_ins[31:25], i_ins[11:7]};
      IMM_B:   o_imm = {{19{i_ins[31]}}, i_ins[31], i_ins[7], i_ins[30:25], i_ins[11:8], 1'b0};
      IMM_U:   o_imm = {i_ins[31:12], 12'b0};
      IMM_J:   o_imm = {{11{i_ins[31]}}, i_ins[31], i_ins[19:12], i_ins[20], i_ins[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060124_idu.sv
// RV32I decode stage: one-entry register between fetch and execute, decode from the held entry.
// Define YSYX_23060124_RV32E_EN to flag any used register index >= 16 as illegal.
//
// Handshake: a beat moves on a side only in a cycle where its valid and ready are both high
// at the rising edge; valid never waits for ready, and o_pre_ready never looks at i_pre_valid.
module ysyx_23060124_idu #(
  parameter int                    ISA_WIDTH      = ysyx_23060124_idu_pkg::ISA_WIDTH,
  parameter logic [ISA_WIDTH-1:0]  RESET_PC       = ysyx_23060124_idu_pkg::RESET_PC,
  parameter int                    REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      idu_rst,
  input  logic [ISA_WIDTH-1:0]      i_ins,
  input  logic [ISA_WIDTH-1:0]      i_pc,
  input  logic                      i_pre_valid,
  output logic                      o_pre_ready,
  input  logic                      i_flush,
  input  logic                      i_post_ready,
  output logic                      o_post_valid,
  output logic [ISA_WIDTH-1:0]      o_pc,
  output logic [ISA_WIDTH-1:0]      o_imm,
  output logic [REG_ADDR_WIDTH-1:0] o_rs1,
  output logic [REG_ADDR_WIDTH-1:0] o_rs2,
  output logic [REG_ADDR_WIDTH-1:0] o_rd,
  output logic [3:0]                o_alu_op,
  output logic                      o_alu_src_imm,
  output logic                      o_alu_src_pc,
  output logic                      o_wen,
  output logic                      o_mem_ren,
  output logic                      o_mem_wen,
  output logic [2:0]                o_mem_funct3,
  output logic                      o_branch,
  output logic                      o_jal,
  output logic                      o_jalr,
  output logic                      o_ecall,
  output logic                      o_ebreak,
  output logic                      o_illegal
);
  import ysyx_23060124_idu_pkg::*;

  idu_state_e           state_q, state_d;
  logic [ISA_WIDTH-1:0] ins_q, ins_d;
  logic [ISA_WIDTH-1:0] pc_q, pc_d;
  logic                 accept;

  assign o_post_valid = (state_q == ST_FULL);
  assign o_pre_ready  = ~o_post_valid | i_post_ready;
  assign accept       = i_pre_valid & o_pre_ready & ~i_flush;

  always_comb begin
    state_d = state_q;
    ins_d   = ins_q;
    pc_d    = pc_q;
    if (i_flush) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d = ST_FULL;
      ins_d   = i_ins;
      pc_d    = i_pc;
    end else if (o_post_valid && i_post_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (idu_rst) begin
      state_q <= ST_EMPTY;
      ins_q   <= ISA_WIDTH'(NOP_INS);
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      ins_q   <= ins_d;
      pc_q    <= pc_d;
    end
  end

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = ins_q[6:0];
  assign funct3 = ins_q[14:12];
  assign funct7 = ins_q[31:25];

  alu_op_e  alu_op;
  imm_fmt_e fmt, fmt_sel;
  logic     src_imm, src_pc, wen, mem_ren, mem_wen;
  logic     branch, jal, jalr, ecall, ebreak, dec_ill, reg_ill, illegal;

  always_comb begin
    alu_op  = ALU_ADD;
    fmt     = IMM_Z;
    src_imm = 1'b0;
    src_pc  = 1'b0;
    wen     = 1'b0;
    mem_ren = 1'b0;
    mem_wen = 1'b0;
    branch  = 1'b0;
    jal     = 1'b0;
    jalr    = 1'b0;
    ecall   = 1'b0;
    ebreak  = 1'b0;
    dec_ill = 1'b0;
    case (opcode)
      OPC_LUI: begin
        wen = 1'b1; src_imm = 1'b1; alu_op = ALU_PASSB; fmt = IMM_U;
      end
      OPC_AUIPC: begin
        wen = 1'b1; src_imm = 1'b1; src_pc = 1'b1; fmt = IMM_U;
      end
      OPC_JAL: begin
        wen = 1'b1; src_pc = 1'b1; jal = 1'b1; fmt = IMM_J;
      end
      OPC_JALR: begin
        wen = 1'b1; src_pc = 1'b1; jalr = 1'b1; fmt = IMM_I;
        dec_ill = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        branch = 1'b1; alu_op = ALU_SUB; fmt = IMM_B;
        dec_ill = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LOAD: begin
        wen = 1'b1; mem_ren = 1'b1; src_imm = 1'b1; fmt = IMM_I;
        dec_ill = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        mem_wen = 1'b1; src_imm = 1'b1; fmt = IMM_S;
        dec_ill = (funct3 > 3'b010);
      end
      OPC_OP_IMM: begin
        wen = 1'b1; src_imm = 1'b1; fmt = IMM_I;
        // Only the shifts carry funct7; SUB has no immediate form.
        alu_op  = alu_decode(funct3, (funct3 == 3'b101) && funct7[5]);
        dec_ill = ((funct3 == 3'b001) && (funct7 != 7'h00)) ||
                  ((funct3 == 3'b101) && (funct7 != 7'h00) && (funct7 != 7'h20));
      end
      OPC_OP: begin
        wen = 1'b1;
        alu_op  = alu_decode(funct3, funct7[5]);
        dec_ill = !((funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_SYSTEM: begin
        if (ins_q == ISA_WIDTH'(ECALL_INS))       ecall   = 1'b1;
        else if (ins_q == ISA_WIDTH'(EBREAK_INS)) ebreak  = 1'b1;
        else                                      dec_ill = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
    if (ins_q[1:0] != 2'b11) dec_ill = 1'b1;
  end

`ifdef YSYX_23060124_RV32E_EN
  logic use_rs1, use_rs2, use_rd;
  always_comb begin
    use_rd  = (opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL) ||
              (opcode == OPC_JALR) || (opcode == OPC_LOAD) || (opcode == OPC_OP_IMM) ||
              (opcode == OPC_OP);
    use_rs1 = (opcode == OPC_JALR) || (opcode == OPC_BRANCH) || (opcode == OPC_LOAD) ||
              (opcode == OPC_STORE) || (opcode == OPC_OP_IMM) || (opcode == OPC_OP);
    use_rs2 = (opcode == OPC_BRANCH) || (opcode == OPC_STORE) || (opcode == OPC_OP);
    reg_ill = (use_rd & ins_q[11]) | (use_rs1 & ins_q[19]) | (use_rs2 & ins_q[24]);
  end
`else
  assign reg_ill = 1'b0;
`endif

  // An illegal instruction carries no control at all, only its raw fields and pc.
  assign illegal = dec_ill | reg_ill;
  assign fmt_sel = illegal ? IMM_Z : fmt;

  ysyx_23060124_imm_gen #(
    .ISA_WIDTH (ISA_WIDTH)
  ) u_imm_gen (
    .i_ins (ins_q[ISA_WIDTH-1:7]),
    .i_fmt (fmt_sel),
    .o_imm (o_imm)
  );

  assign o_pc          = pc_q;
  assign o_rs1         = ins_q[19:15];
  assign o_rs2         = ins_q[24:20];
  assign o_rd          = ins_q[11:7];
  assign o_mem_funct3  = funct3;
  assign o_alu_op      = illegal ? ALU_ADD : alu_op;
  assign o_alu_src_imm = src_imm & ~illegal;
  assign o_alu_src_pc  = src_pc  & ~illegal;
  assign o_wen         = wen     & ~illegal;
  assign o_mem_ren     = mem_ren & ~illegal;
  assign o_mem_wen     = mem_wen & ~illegal;
  assign o_branch      = branch  & ~illegal;
  assign o_jal         = jal     & ~illegal;
  assign o_jalr        = jalr    & ~illegal;
  assign o_ecall       = ecall   & ~illegal;
  assign o_ebreak      = ebreak  & ~illegal;
  assign o_illegal     = illegal;

endmodule

// File: tb/tb_ysyx_23060124_idu.sv
// Self-checking bench for ysyx_23060124_idu: directed instruction vectors into an expected
// queue, a negedge monitor pops one entry per output transfer, plus handshake/flush/reset checks.
module tb_ysyx_23060124_idu;
  import ysyx_23060124_idu_pkg::*;

  logic        clk = 1'b0;
  logic        idu_rst = 1'b1;
  logic [31:0] i_ins = 32'h0;
  logic [31:0] i_pc = 32'h0;
  logic        i_pre_valid = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_post_ready = 1'b1;
  logic        o_pre_ready, o_post_valid;
  logic [31:0] o_pc, o_imm;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [3:0]  o_alu_op;
  logic        o_alu_src_imm, o_alu_src_pc, o_wen, o_mem_ren, o_mem_wen;
  logic [2:0]  o_mem_funct3;
  logic        o_branch, o_jal, o_jalr, o_ecall, o_ebreak, o_illegal;

  ysyx_23060124_idu dut (
    .clk (clk), .idu_rst (idu_rst), .i_ins (i_ins), .i_pc (i_pc),
    .i_pre_valid (i_pre_valid), .o_pre_ready (o_pre_ready), .i_flush (i_flush),
    .i_post_ready (i_post_ready), .o_post_valid (o_post_valid), .o_pc (o_pc),
    .o_imm (o_imm), .o_rs1 (o_rs1), .o_rs2 (o_rs2), .o_rd (o_rd), .o_alu_op (o_alu_op),
    .o_alu_src_imm (o_alu_src_imm), .o_alu_src_pc (o_alu_src_pc), .o_wen (o_wen),
    .o_mem_ren (o_mem_ren), .o_mem_wen (o_mem_wen), .o_mem_funct3 (o_mem_funct3),
    .o_branch (o_branch), .o_jal (o_jal), .o_jalr (o_jalr), .o_ecall (o_ecall),
    .o_ebreak (o_ebreak), .o_illegal (o_illegal)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  localparam logic [10:0] C_IMM = 11'h400, C_PC = 11'h200, C_WEN = 11'h100, C_REN = 11'h080;
  localparam logic [10:0] C_MWEN = 11'h040, C_BR = 11'h020, C_JAL = 11'h010, C_JALR = 11'h008;
  localparam logic [10:0] C_ECALL = 11'h004, C_EBREAK = 11'h002, C_ILL = 11'h001;

  int          checks = 0;
  int          errors = 0;
  logic [96:0] exp_q[$];
  logic [96:0] got_v, exp_v;

  function automatic logic [96:0] mk(input logic [31:0] pc, input logic [31:0] imm,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [4:0] rd, input logic [3:0] alu,
                                     input logic [2:0] f3, input logic [10:0] ctl);
    return {pc, imm, rs1, rs2, rd, alu, ctl[10:6], f3, ctl[5:0]};
  endfunction

  assign got_v = {o_pc, o_imm, o_rs1, o_rs2, o_rd, o_alu_op, o_alu_src_imm, o_alu_src_pc,
                  o_wen, o_mem_ren, o_mem_wen, o_mem_funct3, o_branch, o_jal, o_jalr,
                  o_ecall, o_ebreak, o_illegal};

  always @(negedge clk) begin
    if (!idu_rst && !i_flush && o_post_valid && i_post_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL bundle: unexpected output %h with nothing expected", got_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL bundle pc=%h: got %h expected %h", exp_v[96:65], got_v, exp_v);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input bit push,
                      input logic [96:0] exp);
    i_ins = ins;
    i_pc = pc;
    i_pre_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (o_pre_ready && !i_flush) begin
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: pc %h not accepted within 20 cycles", pc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idu_rst = 1'b1;
    repeat (2) cyc();
    idu_rst = 1'b0;
    @(negedge clk);
    check("rst_post_valid", o_post_valid, 0);
    check("rst_pre_ready", o_pre_ready, 1);
    check("rst_pc", o_pc, 32'h8000_0000);
    check("rst_rd", o_rd, 0);
    check("rst_wen", o_wen, 1);
    check("rst_alu_op", o_alu_op, ALU_ADD);
    check("rst_imm", o_imm, 0);
    check("rst_illegal", o_illegal, 0);
    cyc();

    send(32'h0050_0093, 32'h8000_0000, 1,
         mk(32'h8000_0000, 32'd5, 5'd0, 5'd5, 5'd1, ALU_ADD, 3'd0, C_IMM | C_WEN));
    i_pre_valid = 1'b0;
    cyc();

    // Stall: execute not ready while an entry is held.
    i_post_ready = 1'b0;
    send(32'hFFF0_8113, 32'h8000_0004, 1,
         mk(32'h8000_0004, 32'hFFFF_FFFF, 5'd1, 5'd31, 5'd2, ALU_ADD, 3'd0, C_IMM | C_WEN));
    i_ins = 32'h1234_52B7;
    i_pc = 32'h8000_0008;
    i_pre_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_pre_ready", o_pre_ready, 0);
      check("stall_post_valid", o_post_valid, 1);
      check("stall_pc", o_pc, 32'h8000_0004);
      check("stall_rd", o_rd, 2);
      check("stall_imm", o_imm, 32'hFFFF_FFFF);
      cyc();
    end
    i_post_ready = 1'b1;
    send(32'h1234_52B7, 32'h8000_0008, 1,
         mk(32'h8000_0008, 32'h1234_5000, 5'd8, 5'd3, 5'd5, ALU_PASSB, 3'd5, C_IMM | C_WEN));

    // Back-to-back stream at full throughput.
    send(32'hFE20_8CE3, 32'h8000_000C, 1,
         mk(32'h8000_000C, 32'hFFFF_FFF8, 5'd1, 5'd2, 5'd25, ALU_SUB, 3'd0, C_BR));
    send(32'h0020_A423, 32'h8000_0010, 1,
         mk(32'h8000_0010, 32'd8, 5'd1, 5'd2, 5'd8, ALU_ADD, 3'd2, C_IMM | C_MWEN));
    send(32'h4020_81B3, 32'h8000_0014, 1,
         mk(32'h8000_0014, 32'd0, 5'd1, 5'd2, 5'd3, ALU_SUB, 3'd0, C_WEN));
    send(32'h4030_D213, 32'h8000_0018, 1,
         mk(32'h8000_0018, 32'h0000_0403, 5'd1, 5'd3, 5'd4, ALU_SRA, 3'd5, C_IMM | C_WEN));
    send(32'h0000_0000, 32'h8000_001C, 1,
         mk(32'h8000_001C, 32'd0, 5'd0, 5'd0, 5'd0, ALU_ADD, 3'd0, C_ILL));
    send(32'h0010_0073, 32'h8000_0020, 1,
         mk(32'h8000_0020, 32'd0, 5'd0, 5'd1, 5'd0, ALU_ADD, 3'd0, C_EBREAK));
    send(32'h0000_0073, 32'h8000_0024, 1,
         mk(32'h8000_0024, 32'd0, 5'd0, 5'd0, 5'd0, ALU_ADD, 3'd0, C_ECALL));
    send(32'h0001_3083, 32'h8000_0028, 1,
         mk(32'h8000_0028, 32'd0, 5'd2, 5'd0, 5'd1, ALU_ADD, 3'd3, C_ILL));
    send(32'h0100_00EF, 32'h8000_002C, 1,
         mk(32'h8000_002C, 32'd16, 5'd0, 5'd16, 5'd1, ALU_ADD, 3'd0, C_PC | C_WEN | C_JAL));
`ifdef YSYX_23060124_RV32E_EN
    send(32'h0010_0813, 32'h8000_0030, 1,
         mk(32'h8000_0030, 32'd0, 5'd0, 5'd1, 5'd16, ALU_ADD, 3'd0, C_ILL));
`else
    send(32'h0010_0813, 32'h8000_0030, 1,
         mk(32'h8000_0030, 32'd1, 5'd0, 5'd1, 5'd16, ALU_ADD, 3'd0, C_IMM | C_WEN));
`endif
    i_pre_valid = 1'b0;
    repeat (2) cyc();

    // Flush while FULL with a beat offered that would otherwise be accepted.
    i_post_ready = 1'b0;
    send(32'h0050_0093, 32'h8000_0040, 0, '0);
    i_ins = 32'h1234_52B7;
    i_pc = 32'h8000_0044;
    i_pre_valid = 1'b1;
    i_post_ready = 1'b1;
    i_flush = 1'b1;
    cyc();
    i_flush = 1'b0;
    i_pre_valid = 1'b0;
    @(negedge clk);
    check("flush_post_valid", o_post_valid, 0);
    cyc();
    @(negedge clk);
    check("flush_beat_dropped", o_post_valid, 0);
    cyc();

    // Reset mid-stream discards the held entry.
    i_post_ready = 1'b0;
    send(32'h0050_0093, 32'h8000_0100, 0, '0);
    i_pre_valid = 1'b0;
    idu_rst = 1'b1;
    cyc();
    idu_rst = 1'b0;
    i_post_ready = 1'b1;
    @(negedge clk);
    check("midrst_post_valid", o_post_valid, 0);
    check("midrst_pc", o_pc, 32'h8000_0000);
    cyc();

    send(32'h0050_0093, 32'h8000_0200, 1,
         mk(32'h8000_0200, 32'd5, 5'd0, 5'd5, 5'd1, ALU_ADD, 3'd0, C_IMM | C_WEN));
    i_pre_valid = 1'b0;
    repeat (3) cyc();
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
